// File: rtl/manual_signal_pkg.sv
// Shared types and constants for the manual tail-light controller:
// mode encoding, 7-segment glyphs and the sequential turn pattern.
package manual_signal_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HAZARD,
      TURN_L,
      TURN_R,
      BRAKE,
      BRAKE_TURN_L,
      BRAKE_TURN_R
   } modeT;

   // Active-low segments, bit 7 is the decimal point (kept off).
   localparam logic [7:0] SEG_HAZARD = 8'h89;
   localparam logic [7:0] SEG_TURN_L = 8'hC7;
   localparam logic [7:0] SEG_TURN_R = 8'hAF;
   localparam logic [7:0] SEG_BRAKE  = 8'h83;
   localparam logic [7:0] SEG_IDLE   = 8'hBF;
   localparam logic [7:0] SEG_BLANK  = 8'hFF;

   // Lamps fill outward from the innermost one (bit 0) as phase grows.
   function automatic logic [2:0] turnPattern(input logic [1:0] phase);
      logic [2:0] pat;
      case (phase)
         2'd0:    pat = 3'b000;
         2'd1:    pat = 3'b001;
         2'd2:    pat = 3'b011;
         default: pat = 3'b111;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/manual_tick_gen.sv
// Animation prescaler: counts 0..TICK_DIV-1 and emits a one-cycle tick
// on the terminal count. A synchronous clear restarts the count at 0.
module manual_tick_gen #(
   parameter int TICK_DIV = 2_500_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] countReg;

   assign tick = (countReg == LAST);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         countReg <= '0;
      end else if (tick) begin
         countReg <= '0;
      end else begin
         countReg <= countReg + CNT_W'(1);
      end
   end

endmodule

// File: rtl/manual_signal_ctrl.sv
// Manual-mode tail-light controller: switch decode, turn animation, LED bar
// and mode letter on HEX0 (decoder present only with MANUAL_SIGNAL_CTRL_HEX_EN).
module manual_signal_ctrl
   import manual_signal_pkg::*;
#(
   parameter int TICK_DIV = 2_500_000
) (
   input  logic       ADC_CLK_10,
   input  logic       reset,
   input  logic [1:0] KEY,
   input  logic [9:0] SW,
   output logic [9:0] LEDR,
   output logic [7:0] HEX0
);

   modeT       modeReg;
   modeT       modeNext;
   logic       modeChange;
   logic       tick;
   logic [1:0] phaseReg;
   logic [1:0] phaseNext;
   logic [2:0] pat;
   logic [9:0] ledReg;
   logic [9:0] ledNext;
   logic       unusedInputs;

   assign unusedInputs = ^{KEY[0], SW[9:3]};

   always_comb begin
      modeNext = IDLE;
      if (SW[0]) begin
         modeNext = HAZARD;
      end else if (SW[2]) begin
         if (SW[1]) begin
            modeNext = KEY[1] ? BRAKE_TURN_L : BRAKE_TURN_R;
         end else begin
            modeNext = BRAKE;
         end
      end else if (SW[1]) begin
         modeNext = KEY[1] ? TURN_L : TURN_R;
      end
   end

   assign modeChange = (modeNext != modeReg);

   manual_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk   (ADC_CLK_10),
      .reset (reset),
      .clear (modeChange),
      .tick  (tick)
   );

   // A new mode always restarts its animation from the dark phase.
   always_comb begin
      phaseNext = phaseReg;
      if (modeChange) begin
         phaseNext = 2'd0;
      end else if (tick) begin
         phaseNext = phaseReg + 2'd1;
      end
   end

   // Outputs are computed from the values the state is about to take, so the
   // registered LEDR always matches the registered mode and phase.
   always_comb begin
      pat     = turnPattern(phaseNext);
      ledNext = '0;
      case (modeNext)
         HAZARD:       ledNext = {10{phaseNext[0]}};
         TURN_L:       ledNext = {pat, 7'b0};
         TURN_R:       ledNext = {7'b0, pat};
         BRAKE:        ledNext = '1;
         BRAKE_TURN_L: ledNext = {pat, 7'h7F};
         BRAKE_TURN_R: ledNext = {7'h7F, pat};
         default:      ledNext = '0;
      endcase
   end

   always_ff @(posedge ADC_CLK_10) begin
      if (reset) begin
         modeReg  <= IDLE;
         phaseReg <= 2'd0;
         ledReg   <= '0;
      end else begin
         modeReg  <= modeNext;
         phaseReg <= phaseNext;
         ledReg   <= ledNext;
      end
   end

   assign LEDR = ledReg;

`ifdef MANUAL_SIGNAL_CTRL_HEX_EN
   logic [7:0] hexReg;
   logic [7:0] hexNext;

   always_comb begin
      hexNext = SEG_IDLE;
      case (modeNext)
         HAZARD:                            hexNext = SEG_HAZARD;
         TURN_L:                            hexNext = SEG_TURN_L;
         TURN_R:                            hexNext = SEG_TURN_R;
         BRAKE, BRAKE_TURN_L, BRAKE_TURN_R: hexNext = SEG_BRAKE;
         default:                           hexNext = SEG_IDLE;
      endcase
   end

   always_ff @(posedge ADC_CLK_10) begin
      if (reset) begin
         hexReg <= SEG_BLANK;
      end else begin
         hexReg <= hexNext;
      end
   end

   assign HEX0 = hexReg;
`else
   assign HEX0 = SEG_BLANK;
`endif

endmodule

// File: tb/tb_manual_signal_ctrl.sv
// Self-checking bench for manual_signal_ctrl: a per-cycle reference model
// plus directed sequences with literal expected values.
module tb_manual_signal_ctrl;

   localparam int TICK_DIV = 2;

   localparam int M_IDLE = 0;
   localparam int M_HAZ  = 1;
   localparam int M_TL   = 2;
   localparam int M_TR   = 3;
   localparam int M_BR   = 4;
   localparam int M_BTL  = 5;
   localparam int M_BTR  = 6;

`ifdef MANUAL_SIGNAL_CTRL_HEX_EN
   localparam logic [7:0] X_IDLE = 8'hBF;
   localparam logic [7:0] X_HAZ  = 8'h89;
   localparam logic [7:0] X_TR   = 8'hAF;
   localparam logic [7:0] X_BRK  = 8'h83;
`else
   localparam logic [7:0] X_IDLE = 8'hFF;
   localparam logic [7:0] X_HAZ  = 8'hFF;
   localparam logic [7:0] X_TR   = 8'hFF;
   localparam logic [7:0] X_BRK  = 8'hFF;
`endif
   localparam logic [7:0] X_BLANK = 8'hFF;

   logic       ADC_CLK_10 = 1'b0;
   logic       reset      = 1'b1;
   logic [1:0] KEY        = 2'b00;
   logic [9:0] SW         = 10'h000;
   logic [9:0] LEDR;
   logic [7:0] HEX0;

   int errors = 0;
   int checks = 0;

   manual_signal_ctrl #(
      .TICK_DIV (TICK_DIV)
   ) dut (
      .ADC_CLK_10 (ADC_CLK_10),
      .reset      (reset),
      .KEY        (KEY),
      .SW         (SW),
      .LEDR       (LEDR),
      .HEX0       (HEX0)
   );

   always #50 ADC_CLK_10 = ~ADC_CLK_10;

   task automatic checkVal(input string name, input logic [9:0] act, input logic [9:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int decodeMode(input logic [9:0] sw, input logic [1:0] key);
      if (sw[0]) return M_HAZ;
      if (sw[2]) begin
         if (sw[1]) return key[1] ? M_BTL : M_BTR;
         return M_BR;
      end
      if (sw[1]) return key[1] ? M_TL : M_TR;
      return M_IDLE;
   endfunction

   // Phase n lights the n innermost lamps of a side.
   function automatic logic [9:0] ledFor(input int mode, input int phase);
      logic [2:0] p;
      p = 3'((1 << phase) - 1);
      case (mode)
         M_HAZ:   return (phase % 2 == 1) ? 10'h3FF : 10'h000;
         M_TL:    return {p, 7'h00};
         M_TR:    return {7'h00, p};
         M_BR:    return 10'h3FF;
         M_BTL:   return {p, 7'h7F};
         M_BTR:   return {7'h7F, p};
         default: return 10'h000;
      endcase
   endfunction

   function automatic logic [7:0] hexFor(input int mode);
      case (mode)
         M_HAZ:                return X_HAZ;
         M_TR:                 return X_TR;
         M_BR, M_BTL, M_BTR:   return X_BRK;
`ifdef MANUAL_SIGNAL_CTRL_HEX_EN
         M_TL:                 return 8'hC7;
`else
         M_TL:                 return 8'hFF;
`endif
         default:              return X_IDLE;
      endcase
   endfunction

   // Model: mode held since the last change, and its age in cycles.
   int mMode   = M_IDLE;
   int mAge    = 0;
   bit mRst    = 1'b1;
   bit started = 1'b0;

   always @(posedge ADC_CLK_10) begin
      int d;
      if (reset) begin
         mRst  = 1'b1;
         mMode = M_IDLE;
         mAge  = 0;
      end else begin
         mRst = 1'b0;
         d    = decodeMode(SW, KEY);
         if (d != mMode) begin
            mMode = d;
            mAge  = 0;
         end else begin
            mAge++;
         end
      end
      started = 1'b1;
   end

   always @(negedge ADC_CLK_10) begin
      logic [9:0] expLed;
      logic [7:0] expHex;
      if (started) begin
         expLed = mRst ? 10'h000 : ledFor(mMode, (mAge / TICK_DIV) % 4);
         expHex = mRst ? X_BLANK : hexFor(mMode);
         checkVal("model_ledr", LEDR, expLed);
         checkVal("model_hex0", {2'b00, HEX0}, {2'b00, expHex});
      end
   end

   task automatic expectOut(input string name, input logic [9:0] led, input logic [7:0] hex);
      @(negedge ADC_CLK_10);
      #1;
      checkVal({name, "_ledr"}, LEDR, led);
      checkVal({name, "_hex0"}, {2'b00, HEX0}, {2'b00, hex});
   endtask

   logic [9:0] hazSeq [6] = '{10'h000, 10'h000, 10'h3FF, 10'h3FF, 10'h000, 10'h000};
   logic [9:0] rtSeq  [5] = '{10'h000, 10'h000, 10'h001, 10'h001, 10'h003};
   logic [9:0] lbSeq  [9] = '{10'h07F, 10'h07F, 10'h0FF, 10'h0FF, 10'h1FF,
                              10'h1FF, 10'h3FF, 10'h3FF, 10'h07F};
   logic [9:0] rbSeq  [5] = '{10'h3F8, 10'h3F8, 10'h3F9, 10'h3F9, 10'h3FB};

   initial begin
      expectOut("rst0", 10'h000, X_BLANK);
      expectOut("rst1", 10'h000, X_BLANK);
      expectOut("rst2", 10'h000, X_BLANK);
      reset = 1'b0;

      expectOut("idle0", 10'h000, X_IDLE);
      expectOut("idle1", 10'h000, X_IDLE);

      SW = 10'h001;
      for (int i = 0; i < 6; i++) expectOut($sformatf("haz%0d", i), hazSeq[i], X_HAZ);

      SW  = 10'h002;
      KEY = 2'b00;
      for (int i = 0; i < 5; i++) expectOut($sformatf("rturn%0d", i), rtSeq[i], X_TR);

      // Hazard overrides the turn mid-sequence and restarts at phase 0.
      SW = 10'h003;
      expectOut("prio0", 10'h000, X_HAZ);
      expectOut("prio1", 10'h000, X_HAZ);
      expectOut("prio2", 10'h3FF, X_HAZ);

      reset = 1'b1;
      SW    = 10'h000;
      expectOut("midrst0", 10'h000, X_BLANK);
      expectOut("midrst1", 10'h000, X_BLANK);
      reset = 1'b0;
      expectOut("postrst", 10'h000, X_IDLE);

      SW  = 10'h006;
      KEY = 2'b10;
      for (int i = 0; i < 9; i++) expectOut($sformatf("lbrake%0d", i), lbSeq[i], X_BRK);

      KEY = 2'b00;
      for (int i = 0; i < 5; i++) expectOut($sformatf("rbrake%0d", i), rbSeq[i], X_BRK);

      SW = 10'h004;
      expectOut("brake0", 10'h3FF, X_BRK);
      expectOut("brake1", 10'h3FF, X_BRK);

      SW  = 10'h3F8;
      KEY = 2'b01;
      expectOut("ignored0", 10'h000, X_IDLE);
      expectOut("ignored1", 10'h000, X_IDLE);

      @(negedge ADC_CLK_10);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
